// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares the buzzer between music and one-shot effects; `define SFX_PREEMPT_EN lets higher-priority effects abort a playing one
module buzzer_arbiter #(
  parameter int unsigned SFX_LEN = 25_000_000,
  parameter int unsigned GAP_LEN = 5_000_000,
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_startmusic,
  input  logic       enable_gamemusic,
  input  logic       req_shoot,
  input  logic       req_reward,
  input  logic       req_hit,
  output logic [2:0] src_sel,
  output logic       buzzer_en,
  output logic       sfx_busy,
  output logic [2:0] pending
);
  typedef enum logic [1:0] {IDLE, MUSIC, SFX, GAP} state_t;
  localparam logic [CNT_W-1:0] SFX_END = CNT_W'(SFX_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LEN - 1);
  state_t state, state_n, rule_state;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] src_n, best, best_oh, music, rule_src, clr;
  logic preempt;
  assign best = pending[2] ? 3'd5 : pending[1] ? 3'd4 : pending[0] ? 3'd3 : 3'd0;
  assign best_oh = pending[2] ? 3'b100 : pending[1] ? 3'b010 : pending[0] ? 3'b001 : 3'b000;
  assign music = enable_startmusic ? 3'd1 : enable_gamemusic ? 3'd2 : 3'd0;
  assign rule_state = best != 3'd0 ? SFX : music != 3'd0 ? MUSIC : IDLE;
  assign rule_src = best != 3'd0 ? best : music;
`ifdef SFX_PREEMPT_EN
  assign preempt = best > src_sel;
`else
  assign preempt = 1'b0;
`endif
  // next state: effects first, then music, then silence; SFX/GAP run to their terminal count
  always_comb begin
    state_n = state;
    src_n = src_sel;
    cnt_n = cnt;
    clr = 3'b000;
    case (state)
      IDLE, MUSIC: begin
        state_n = rule_state;
        src_n = rule_src;
        cnt_n = '0;
        clr = best_oh;
      end
      SFX: begin
        if (preempt) begin
          src_n = best;
          cnt_n = '0;
          clr = best_oh;
        end else if (cnt == SFX_END) begin
          if (GAP_LEN == 0) begin
            state_n = rule_state;
            src_n = rule_src;
            cnt_n = '0;
            clr = best_oh;
          end else begin
            state_n = GAP;
            src_n = 3'd0;
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_END) begin
          state_n = rule_state;
          src_n = rule_src;
          cnt_n = '0;
          clr = best_oh;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        src_n = 3'd0;
        cnt_n = '0;
      end
    endcase
  end
  // state, counter, pending latch and registered outputs; a new pulse re-arms a bit cleared on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      src_sel <= 3'd0;
      buzzer_en <= 1'b0;
      sfx_busy <= 1'b0;
      pending <= 3'b000;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      src_sel <= src_n;
      buzzer_en <= src_n != 3'd0;
      sfx_busy <= state_n == SFX || state_n == GAP;
      pending <= (pending & ~clr) | {req_hit, req_reward, req_shoot};
    end
  end
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed checks of music selection, effect priority, merge, replay, preemption and reset
module tb_buzzer_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_startmusic = 1'b0;
  logic enable_gamemusic = 1'b0;
  logic req_shoot = 1'b0;
  logic req_reward = 1'b0;
  logic req_hit = 1'b0;
  logic [2:0] src_sel;
  logic buzzer_en;
  logic sfx_busy;
  logic [2:0] pending;
  int checks = 0;
  int errors = 0;
  buzzer_arbiter #(.SFX_LEN(4), .GAP_LEN(2), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .enable_startmusic(enable_startmusic),
    .enable_gamemusic(enable_gamemusic),
    .req_shoot(req_shoot),
    .req_reward(req_reward),
    .req_hit(req_hit),
    .src_sel(src_sel),
    .buzzer_en(buzzer_en),
    .sfx_busy(sfx_busy),
    .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] es, input logic eb, input logic [2:0] ep);
    checks++;
    assert ({src_sel, buzzer_en, sfx_busy, pending} === {es, es != 3'd0, eb, ep}) else begin
      errors++;
      $error("FAIL %s: got sel=%0d en=%0b busy=%0b pend=%b, expected sel=%0d en=%0b busy=%0b pend=%b",
             tag, src_sel, buzzer_en, sfx_busy, pending, es, es != 3'd0, eb, ep);
    end
  endtask
  function automatic logic on(input string s, input int i);
    return s.len() > i && s[i] == 8'h31;
  endfunction
  task automatic seq(input string tag, input string sel, input string busy, input string pend,
                     input string sh, input string rw, input string hi);
    for (int i = 0; i < sel.len(); i++) begin
      req_shoot = on(sh, i);
      req_reward = on(rw, i);
      req_hit = on(hi, i);
      tick();
      req_shoot = 1'b0;
      req_reward = 1'b0;
      req_hit = 1'b0;
      chk($sformatf("%s[%0d]", tag, i), 3'(sel[i] - 8'h30), busy[i] == 8'h31, 3'(pend[i] - 8'h30));
    end
  endtask
  initial begin
    req_shoot = 1'b1;
    req_reward = 1'b1;
    req_hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", 3'd0, 1'b0, 3'b000);
    end
    rst = 1'b0;
    req_shoot = 1'b0;
    req_reward = 1'b0;
    req_hit = 1'b0;
    tick();
    chk("post_reset", 3'd0, 1'b0, 3'b000);
    enable_startmusic = 1'b1;
    tick();
    chk("start_music", 3'd1, 1'b0, 3'b000);
    enable_startmusic = 1'b0;
    enable_gamemusic = 1'b1;
    tick();
    chk("game_music", 3'd2, 1'b0, 3'b000);
    enable_gamemusic = 1'b0;
    tick();
    chk("music_off", 3'd0, 1'b0, 3'b000);
    enable_gamemusic = 1'b1;
    enable_startmusic = 1'b1;
    tick();
    chk("music_prio", 3'd1, 1'b0, 3'b000);
    enable_startmusic = 1'b0;
    tick();
    chk("music_back", 3'd2, 1'b0, 3'b000);
    seq("preempt_music", "23333002", "01111110", "10000000", "1", "", "");
    enable_gamemusic = 1'b0;
    tick();
    chk("idle", 3'd0, 1'b0, 3'b000);
    seq("priority", "05555004444003333000", "01111111111111111110", "73333331111110000000", "1101", "1", "1");
    seq("replay", "05555005555000", "01111111111110", "40444440000000", "", "", "101");
`ifdef SFX_PREEMPT_EN
    seq("sfx_preempt", "0335555000", "0111111110", "1040000000", "1", "", "001");
`else
    seq("sfx_no_preempt", "03333005555000", "01111111111110", "10444440000000", "1", "", "001");
`endif
    seq("pre_rst", "05", "01", "40", "", "", "1");
    rst = 1'b1;
    tick();
    chk("rst_mid_sfx", 3'd0, 1'b0, 3'b000);
    rst = 1'b0;
    tick();
    chk("after_rst", 3'd0, 1'b0, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
